// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage and its IF/ID pipeline register.
//
// It owns the PC and a level request/ack handshake to instruction memory.
// Each acked word is handed to decode through the IF/ID register.
// Taken branches from decode redirect the PC after the delay slot, which is
// the instruction at the current pc. When that delay-slot fetch has not been
// acked yet, the target is parked in a pending register until the ack arrives.
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst              synchronous reset, active low
//   stall_i[5:0]     ctrl stall vector: [0] PC, [1] IF/ID, [2] decode
//   branch_flag_i    decode: taken branch/jump this cycle
//   branch_target_i  decode: branch target; bits [1:0] ignored
//   inst_req_o       instruction memory request (level)
//   inst_addr_o      fetch address (word aligned pc)
//   inst_ack_i       memory: inst_data_i valid, completes the request
//   inst_data_i      fetched instruction word
//   stallreq_o       to ctrl: fetch outstanding and not acked this cycle
//   pc_o / inst_o    IF/ID register contents presented to decode
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ack_i,
    input  logic [31:0] inst_data_i,
    output logic        stallreq_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] pc_o_q, pc_o_d;
    logic [31:0] inst_o_q, inst_o_d;

    logic        advance;
    logic        accept;
    logic        take_now;
    logic [31:0] target_aligned;

    // Upper stall bits belong to later stages; target low bits are dropped.
    logic unused_bits;
    assign unused_bits = ^{stall_i[5:3], branch_target_i[1:0]};

    // Request is abandoned outright during reset; memory must tolerate that.
    assign inst_req_o  = rst;
    assign inst_addr_o = {pc_q[31:2], 2'b00};
    assign stallreq_o  = inst_req_o & ~inst_ack_i;

    assign target_aligned = {branch_target_i[31:2], 2'b00};

    // advance: the word at pc is consumed this edge and pc may move on.
    // A word acked while PC or IF/ID is stalled is dropped and refetched.
    assign advance  = inst_ack_i & ~stall_i[0] & ~stall_i[1];
    // accept: the branch in decode actually leaves decode this edge.
    assign accept   = branch_flag_i & ~stall_i[2];
    // take_now: the delay slot is captured on the same edge as the branch.
    assign take_now = accept & advance;

    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;

        if (advance) begin
            if (pend_valid_q)  pc_d = pend_target_q;
            else if (take_now) pc_d = target_aligned;
            else               pc_d = pc_q + 32'd4;
            pend_valid_d = 1'b0;
        end else if (accept && !pend_valid_q) begin
            // Delay slot still in flight: remember where to go once it lands.
            // A second accept while pending is illegal and ignored, so the
            // first target is kept.
            pend_valid_d  = 1'b1;
            pend_target_d = target_aligned;
        end
    end

    always_comb begin
        pc_o_d   = pc_o_q;
        inst_o_d = inst_o_q;
        if (stall_i[1]) begin
            // Decode also stalled: hold. Otherwise decode moves on, feed a bubble.
            if (!stall_i[2]) begin
                pc_o_d   = 32'h0;
                inst_o_d = NOP_INST;
            end
        end else if (inst_ack_i) begin
            pc_o_d   = pc_q;
            inst_o_d = inst_data_i;
        end else begin
            pc_o_d   = 32'h0;
            inst_o_d = NOP_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
            pc_o_q        <= 32'h0;
            inst_o_q      <= NOP_INST;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pc_o_q        <= pc_o_d;
            inst_o_q      <= inst_o_d;
        end
    end

    assign pc_o   = pc_o_q;
    assign inst_o = inst_o_q;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'hCAFE_0000;
    localparam logic [31:0] DB  = 32'h1000_0000;  // memory word = DB + address

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (RESET_PC = 0)
    logic        rst, bf, ack, req, sr;
    logic [5:0]  stall;
    logic [31:0] tgt, addr, data, pco, insto;

    if_fetch #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(bf),
        .branch_target_i(tgt), .inst_req_o(req), .inst_addr_o(addr),
        .inst_ack_i(ack), .inst_data_i(data), .stallreq_o(sr),
        .pc_o(pco), .inst_o(insto)
    );
    assign data = DB + addr;

    // wrap instance (RESET_PC = 0xFFFF_FFFC)
    logic        rst2, ack2, req2, sr2;
    logic [31:0] addr2, data2, pco2, insto2;

    if_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut_wrap (
        .clk(clk), .rst(rst2), .stall_i(6'b0), .branch_flag_i(1'b0),
        .branch_target_i(32'h0), .inst_req_o(req2), .inst_addr_o(addr2),
        .inst_ack_i(ack2), .inst_data_i(data2), .stallreq_o(sr2),
        .pc_o(pco2), .inst_o(insto2)
    );
    assign data2 = DB + addr2;

    typedef struct {
        logic        rst;
        logic [5:0]  stall;
        logic        bf;
        logic [31:0] tgt;
        logic        ack;
        logic        ca;     // address known (false before the first reset edge)
        logic [31:0] addr;   // expected fetch address this cycle
        logic        req;
        logic        sr;
        logic [31:0] epc;    // IF/ID after the edge
        logic [31:0] einst;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    vec_t vq[$];
    sb_t  sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // bub: IF/ID expected to hold a bubble; else the word at epc
    task automatic add(input logic r, input logic [5:0] st, input logic b,
                       input logic [31:0] t, input logic a, input logic c,
                       input logic [31:0] ad, input logic bub, input logic [31:0] epc);
        vec_t v;
        v.rst = r; v.stall = st; v.bf = b; v.tgt = t; v.ack = a; v.ca = c;
        v.addr = ad; v.req = r; v.sr = r & ~a;
        v.epc   = bub ? 32'h0 : epc;
        v.einst = bub ? NOP : DB + epc;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        sb_t e;
        rst = 1'b0; stall = '0; bf = 1'b0; tgt = '0; ack = 1'b0;
        rst2 = 1'b0; ack2 = 1'b0;

        //   rst stall     bf tgt         ack ca addr          bub epc
        // reset then straight-line fetch
        add(0, 6'b000000, 0, 32'h0,   1, 0, 32'h0,   1, 0);
        add(0, 6'b000000, 0, 32'h0,   1, 1, 32'h0,   1, 0);
        add(1, 6'b000000, 0, 32'h0,   1, 1, 32'h0,   0, 32'h0);
        add(1, 6'b000000, 0, 32'h0,   1, 1, 32'h4,   0, 32'h4);
        // wait states on 0x8, ctrl mirrors stallreq
        add(1, 6'b000011, 0, 32'h0,   0, 1, 32'h8,   1, 0);
        add(1, 6'b000011, 0, 32'h0,   0, 1, 32'h8,   1, 0);
        add(1, 6'b000000, 0, 32'h0,   1, 1, 32'h8,   0, 32'h8);
        add(1, 6'b000000, 0, 32'h0,   1, 1, 32'hC,   0, 32'hC);
        add(1, 6'b000000, 0, 32'h0,   1, 1, 32'h10,  0, 32'h10);
        // branch, zero-wait delay slot 0x14 -> 0x100
        add(1, 6'b000000, 1, 32'h103, 1, 1, 32'h14,  0, 32'h14);
        add(1, 6'b000000, 0, 32'h0,   1, 1, 32'h100, 0, 32'h100);
        add(1, 6'b000000, 0, 32'h0,   1, 1, 32'h104, 0, 32'h104);
        // jump back to 0x10 so 0x14 comes around again
        add(1, 6'b000000, 1, 32'h13,  1, 1, 32'h108, 0, 32'h108);
        add(1, 6'b000000, 0, 32'h0,   1, 1, 32'h10,  0, 32'h10);
        // branch with late delay slot: 0x14 acked three cycles later
        add(1, 6'b000011, 1, 32'h103, 0, 1, 32'h14,  1, 0);
        add(1, 6'b000011, 0, 32'h0,   0, 1, 32'h14,  1, 0);
        add(1, 6'b000011, 0, 32'h0,   0, 1, 32'h14,  1, 0);
        add(1, 6'b000000, 0, 32'h0,   1, 1, 32'h14,  0, 32'h14);
        add(1, 6'b000000, 0, 32'h0,   1, 1, 32'h100, 0, 32'h100);
        // downstream stall 000111: hold everything, refetch same address
        add(1, 6'b000111, 0, 32'h0,   1, 1, 32'h104, 0, 32'h100);
        add(1, 6'b000111, 0, 32'h0,   1, 1, 32'h104, 0, 32'h100);
        add(1, 6'b000000, 0, 32'h0,   1, 1, 32'h104, 0, 32'h104);
        // stall 000011: bubbles, pc held
        add(1, 6'b000011, 0, 32'h0,   1, 1, 32'h108, 1, 0);
        add(1, 6'b000011, 0, 32'h0,   1, 1, 32'h108, 1, 0);
        add(1, 6'b000000, 0, 32'h0,   1, 1, 32'h108, 0, 32'h108);
        // pending branch, then reset mid-wait (ack during reset ignored)
        add(1, 6'b000011, 1, 32'h40,  0, 1, 32'h10C, 1, 0);
        add(0, 6'b000000, 0, 32'h0,   1, 1, 32'h10C, 1, 0);
        add(1, 6'b000000, 0, 32'h0,   1, 1, 32'h0,   0, 32'h0);
        add(1, 6'b000000, 0, 32'h0,   1, 1, 32'h4,   0, 32'h4);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; stall = vq[i].stall; bf = vq[i].bf;
            tgt = vq[i].tgt; ack = vq[i].ack;
            #1;
            n_vec++;
            chk("inst_req", i, {31'b0, req}, {31'b0, vq[i].req});
            chk("stallreq", i, {31'b0, sr},  {31'b0, vq[i].sr});
            if (vq[i].ca) chk("inst_addr", i, addr, vq[i].addr);
            sb.push_back('{idx: i, pc: vq[i].epc, inst: vq[i].einst});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("pc_o", e.idx, pco, e.pc);
            chk("inst_o", e.idx, insto, e.inst);
        end

        // PC wrap: RESET_PC = 0xFFFF_FFFC, second fetch at 0x0
        @(negedge clk);
        rst2 = 1'b0; ack2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b1;
        #1;
        n_vec++;
        chk("wrap_addr0", 0, addr2, 32'hFFFF_FFFC);
        chk("wrap_req", 0, {31'b0, req2}, 32'h1);
        @(posedge clk);
        #1;
        chk("wrap_pc_o", 0, pco2, 32'hFFFF_FFFC);
        chk("wrap_inst_o", 0, insto2, DB + 32'hFFFF_FFFC);
        chk("wrap_addr1", 1, addr2, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
